// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - shared opcodes, capture pattern and DR-select enum for the TAP data path
package jtag_pkg;

  // Instruction register width used when a block does not override it
  localparam int IR_WIDTH_DEFAULT = 4;

  // Opcodes at the default width; narrower or wider IRs zero-extend these,
  // except BYPASS which is all ones at any width (and is also the decode fallback)
  localparam logic [IR_WIDTH_DEFAULT-1:0] OP_EXTEST = '0;
  localparam logic [IR_WIDTH_DEFAULT-1:0] OP_SAMPLE = 4'b0010;
  localparam logic [IR_WIDTH_DEFAULT-1:0] OP_IDCODE = 4'b0001;
  localparam logic [IR_WIDTH_DEFAULT-1:0] OP_BYPASS = '1;

  // Value loaded into the IR shift stage on Capture-IR: LSBs 01, upper bits 0
  localparam logic [IR_WIDTH_DEFAULT-1:0] IR_CAPTURE_PATTERN = 4'b0001;

  // Which data register the active instruction connects between TDI and TDO
  typedef enum logic [1:0] {
    DR_BYPASS = 2'd0,
    DR_IDCODE = 2'd1,
    DR_BSR    = 2'd2
  } dr_sel_e;

endpackage

// File: rtl/jtag_instruction_register.sv
// rtl/jtag_instruction_register.sv - IR shift/update stages and instruction decoder
module jtag_instruction_register
  import jtag_pkg::*;
#(
  parameter int IR_WIDTH = IR_WIDTH_DEFAULT
) (
  input  logic                TCK,
  input  logic                Reset,
  input  logic                TDI,
  input  logic                ShiftIR,
  input  logic                ClockIR,
  input  logic                UpdateIR,
  output logic [IR_WIDTH-1:0] Instruction,
  output logic                ExtestMode,
  output dr_sel_e             DrSel,
  output logic                IrTdo
);

  // Opcodes resized to this IR width
  localparam logic [IR_WIDTH-1:0] L_EXTEST  = IR_WIDTH'(OP_EXTEST);
  localparam logic [IR_WIDTH-1:0] L_SAMPLE  = IR_WIDTH'(OP_SAMPLE);
  localparam logic [IR_WIDTH-1:0] L_IDCODE  = IR_WIDTH'(OP_IDCODE);
  localparam logic [IR_WIDTH-1:0] L_CAPTURE = IR_WIDTH'(IR_CAPTURE_PATTERN);

  logic [IR_WIDTH-1:0] r_ir_sr;
  logic [IR_WIDTH-1:0] r_instruction;
  dr_sel_e             w_dr_sel;

  // Shift stage: capture fixed pattern or shift right with TDI into the MSB.
  // An UpdateIR on the same edge suppresses capture/shift so the update
  // stage copies a stable value.
  always_ff @(posedge TCK) begin
    if (Reset) begin
      r_ir_sr <= L_CAPTURE;
    end else if (UpdateIR) begin
      r_ir_sr <= r_ir_sr;
    end else if (ClockIR) begin
      if (ShiftIR) begin
        r_ir_sr <= {TDI, r_ir_sr[IR_WIDTH-1:1]};
      end else begin
        r_ir_sr <= L_CAPTURE;
      end
    end
  end

  // Update stage: the active instruction changes only on UpdateIR
  always_ff @(posedge TCK) begin
    if (Reset) begin
      r_instruction <= L_IDCODE;
    end else if (UpdateIR) begin
      r_instruction <= r_ir_sr;
    end
  end

  // Decoder: unused codes fall back to BYPASS
  always_comb begin
    w_dr_sel = DR_BYPASS;
    if (r_instruction == L_EXTEST || r_instruction == L_SAMPLE) begin
      w_dr_sel = DR_BSR;
    end else if (r_instruction == L_IDCODE) begin
      w_dr_sel = DR_IDCODE;
    end
  end

  assign Instruction = r_instruction;
  assign ExtestMode  = (r_instruction == L_EXTEST);
  assign DrSel       = w_dr_sel;
  assign IrTdo       = r_ir_sr[0];

endmodule

// File: rtl/jtag_tap_datapath.sv
// rtl/jtag_tap_datapath.sv - TAP data path: IR, BYPASS, IDCODE, BSR strobes and TDO mux
module jtag_tap_datapath
  import jtag_pkg::*;
#(
  parameter int          IR_WIDTH     = IR_WIDTH_DEFAULT,
  parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001
) (
  input  logic                TCK,
  input  logic                Reset,
  input  logic                TDI,
  input  logic                ShiftIR,
  input  logic                ClockIR,
  input  logic                UpdateIR,
  input  logic                ShiftDR,
  input  logic                ClockDR,
  input  logic                UpdateDR,
  input  logic                Select,
  input  logic                Enable,
  input  logic                BsrTdo,
  output logic                BsrCapture,
  output logic                BsrShift,
  output logic                BsrUpdate,
  output logic                ExtestMode,
  output logic [IR_WIDTH-1:0] Instruction,
  output logic                TDO,
  output logic                TdoOe
);

  dr_sel_e     w_dr_sel;
  logic        w_ir_tdo;
  logic        w_bsr_sel;
  logic        r_bypass;
  logic [31:0] r_idcode_sr;
  logic        w_tdo;

  jtag_instruction_register #(
    .IR_WIDTH (IR_WIDTH)
  ) u_ir (
    .TCK         (TCK),
    .Reset       (Reset),
    .TDI         (TDI),
    .ShiftIR     (ShiftIR),
    .ClockIR     (ClockIR),
    .UpdateIR    (UpdateIR),
    .Instruction (Instruction),
    .ExtestMode  (ExtestMode),
    .DrSel       (w_dr_sel),
    .IrTdo       (w_ir_tdo)
  );

  // BYPASS register: captures 0, shifts TDI, ignores UpdateDR
  always_ff @(posedge TCK) begin
    if (Reset) begin
      r_bypass <= 1'b0;
    end else if (ClockDR && w_dr_sel == DR_BYPASS) begin
      r_bypass <= ShiftDR ? TDI : 1'b0;
    end
  end

  // IDCODE register: captures the device ID, shifts right with TDI into bit 31
  always_ff @(posedge TCK) begin
    if (Reset) begin
      r_idcode_sr <= IDCODE_VALUE;
    end else if (ClockDR && w_dr_sel == DR_IDCODE) begin
      if (ShiftDR) begin
        r_idcode_sr <= {TDI, r_idcode_sr[31:1]};
      end else begin
        r_idcode_sr <= IDCODE_VALUE;
      end
    end
  end

  // Boundary-scan strobes pass through only while EXTEST/SAMPLE is active
  assign w_bsr_sel  = (w_dr_sel == DR_BSR);
  assign BsrCapture = w_bsr_sel & ClockDR & ~ShiftDR;
  assign BsrShift   = w_bsr_sel & ClockDR & ShiftDR;
  assign BsrUpdate  = w_bsr_sel & UpdateDR;

  // TDO mux: IR path when Select is high, otherwise the decoded data register
  always_comb begin
    w_tdo = r_bypass;
    if (Select) begin
      w_tdo = w_ir_tdo;
    end else begin
      case (w_dr_sel)
        DR_IDCODE: w_tdo = r_idcode_sr[0];
        DR_BSR:    w_tdo = BsrTdo;
        default:   w_tdo = r_bypass;
      endcase
    end
  end

  assign TDO   = w_tdo;
  assign TdoOe = Enable;

endmodule

// File: doc/jtag_tap_datapath.md
# jtag_tap_datapath

TCK-domain data path that sits directly downstream of the TAP controller and consumes its ShiftIR/ClockIR/UpdateIR/ShiftDR/ClockDR/UpdateDR/Select/Enable outputs. It contains the instruction register (shift and update stages), the instruction decoder, the BYPASS and IDCODE data registers, strobes for an external boundary-scan register, and the TDO multiplexer. Together with the TAP controller it forms a complete IEEE 1149.1-style test access port.

## Interface
Parameters:
- IR_WIDTH, 4: instruction register width, minimum 2.
- IDCODE_VALUE, 32'h1000_0001: device ID. Bit 0 must be 1.

Ports:
- TCK  in  1: the single clock. Every register updates on the rising edge.
- Reset  in  1: synchronous, active-high reset.
- TDI  in  1: serial test data in.
- ShiftIR, ClockIR, UpdateIR  in  1 each: IR strobes from the TAP controller.
- ShiftDR, ClockDR, UpdateDR  in  1 each: DR strobes from the TAP controller.
- Select  in  1: 1 selects the IR path for TDO, 0 selects the DR path.
- Enable  in  1: TDO output enable from the TAP controller.
- BsrTdo  in  1: serial output of the external boundary-scan register.
- BsrCapture, BsrShift, BsrUpdate  out  1 each: qualified strobes for the external boundary-scan register.
- ExtestMode  out  1: high while the active instruction is EXTEST.
- Instruction  out  IR_WIDTH: active (updated) instruction.
- TDO  out  1: serial test data out.
- TdoOe  out  1: equals Enable.

## Operation
- Opcodes: EXTEST = all zeros, SAMPLE = 0…010, IDCODE = 0…001, BYPASS = all ones. Every other code decodes as BYPASS.
- IR capture: ClockIR & !ShiftIR loads ir_sr with 0…01 (two LSBs are 01, upper bits 0).
- IR shift: ClockIR & ShiftIR shifts ir_sr right, with TDI entering the MSB.
- IR update: UpdateIR copies ir_sr into Instruction.
- DR capture and shift use the same qualification with ClockDR/ShiftDR. Only the register selected by Instruction acts:
  - BYPASS: capture loads 0; shift loads TDI.
  - IDCODE: 32-bit register. Capture loads IDCODE_VALUE; shift goes right with TDI entering bit 31.
  - EXTEST/SAMPLE: BsrCapture = ClockDR & !ShiftDR; BsrShift = ClockDR & ShiftDR; BsrUpdate = UpdateDR. All three are 0 for any other instruction.
- UpdateDR has no effect on BYPASS or IDCODE.
- TDO mux:
  - Select = 1: TDO = ir_sr[0].
  - Select = 0: TDO = bypass, idcode_sr[0] or BsrTdo, chosen by the decoded instruction.
  - TDO is combinational from flops and the mux, with no extra register.
- Priority:
  - Reset beats everything.
  - UpdateIR beats ClockIR if both are asserted (illegal from a correct controller).
  - Instruction never changes except on UpdateIR, so the DR selection is stable during DR scans.

## Timing
- Reset values:
  - Instruction = IDCODE; ExtestMode = 0.
  - ir_sr = 0…01; bypass = 0; idcode_sr = IDCODE_VALUE.
  - Bsr* = 0; TDO = bit 0 of the selected register; TdoOe = Enable.
- Reset asserted mid-scan takes effect at the next TCK edge and discards any partial shift. Instruction returns to IDCODE even if UpdateIR is high on that edge.
- Capture: the value is visible on TDO immediately after the capturing edge. Each following shift edge advances TDO by one bit.
- Serial latency:
  - BYPASS: TDI reaches TDO one edge later.
  - IR: IR_WIDTH edges.
  - IDCODE: 32 edges.
- Update: the new Instruction and ExtestMode are valid after the UpdateIR edge. The BSR strobes follow the new decode from the next edge onward.
- Bsr* outputs are combinational from the strobes and the decode, with zero latency.

## Structure
- Shared package jtag_pkg holds IR_WIDTH default, opcode constants OP_EXTEST/OP_SAMPLE/OP_IDCODE/OP_BYPASS, IR_CAPTURE_PATTERN and the decoded-instruction enum (DR_BYPASS, DR_IDCODE, DR_BSR).
- One sub-module, jtag_instruction_register, holds ir_sr, the update stage and the decoder, and outputs the enum.
- The top level holds the BYPASS register, the IDCODE register, the BSR strobe gating and the TDO mux.

## Test plan
- Reset, then an IDCODE DR scan of 32 shifts with Select = 0 → TDO emits 0x10000001 LSB-first; Instruction = IDCODE.
- IR scan: capture, then shift 1111 (IR_WIDTH = 4), then UpdateIR → TDO shows 1,0,0,0 during the shift; Instruction = 4'hF. A following DR scan with TDI pattern 1011 returns on TDO delayed by one bit, the first bit being the captured 0.
- Load EXTEST (0000) → ExtestMode = 1. A DR capture/shift/update pulses BsrCapture, BsrShift and BsrUpdate on the same edges as the controller strobes; TDO follows BsrTdo.
- Load an unused code 4'h5 → behaves as BYPASS, with a single-bit delay and the Bsr* outputs held at 0.
- Assert Reset in the middle of an IR shift after 2 bits of 0000 → Instruction stays IDCODE, ir_sr = 0001, and the next DR scan returns IDCODE_VALUE.
- Assert UpdateIR and ClockIR together → Instruction takes the old ir_sr, and ir_sr does not capture on that edge.
